adder_sweep_ctrl: RTL and testbench

Hardware sweep controller for one approximate adder under test (any nBitRcpa variant, instantiated outside this block). On start it walks every operand pair (i, j), with i in 0..A_MAX and j in 0..B_MAX, in row-major order, skipping pairs with i+j >= SUM_LIMIT. It drives each accepted pair to the adder and compares the adder's result against the exact sum. It streams one record per pair over a valid/ready port and accumulates error statistics. It replaces exhaustive simulation-only sweeps with a synthesizable evaluator for FPGA error characterisation.

---
 rtl/adder_eval_pkg.sv | 29 ++
 rtl/adder_sweep_ctrl_if.sv | 25 ++
 rtl/err_stats_acc.sv | 78 +++++++
 rtl/adder_sweep_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_adder_sweep_ctrl.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adder_eval_pkg.sv
// Shared types and width helpers for the approximate-adder sweep evaluator.
//   state_e : sweep controller FSM states
//   CW(n)   : width of pair/error counters (2n+1)
//   SW(n)   : width of the error-distance accumulator (3n+1)
//   EW(n)   : width of a sum or error distance (n+1)
package adder_eval_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_APPLY  = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_OUT    = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  function automatic int CW(input int n);
    return 2 * n + 1;
  endfunction

  function automatic int SW(input int n);
    return 3 * n + 1;
  endfunction

  function automatic int EW(input int n);
    return n + 1;
  endfunction

endpackage

// File: rtl/adder_sweep_ctrl_if.sv
// Record stream carrying one evaluated operand pair per valid/ready handshake.
//   master : producer (sweep controller) drives rec_valid and the record fields
//   slave  : consumer drives rec_ready
interface adder_sweep_ctrl_if
  import adder_eval_pkg::*;
#(
  parameter int N = 8
);
  logic             rec_valid;
  logic             rec_ready;
  logic [N-1:0]     rec_a;
  logic [N-1:0]     rec_b;
  logic [EW(N)-1:0] rec_exact;
  logic [EW(N)-1:0] rec_approx;

  modport master (
    output rec_valid, rec_a, rec_b, rec_exact, rec_approx,
    input  rec_ready
  );

  modport slave (
    input  rec_valid, rec_a, rec_b, rec_exact, rec_approx,
    output rec_ready
  );
endinterface

// File: rtl/err_stats_acc.sv
// Error statistics accumulator for the adder sweep.
//   clk, rst            : clock, synchronous active-high reset
//   clr_i               : clears all statistics (start of a new sweep)
//   upd_i               : accumulate the pair presented on exact_i/approx_i
//   exact_i, approx_i   : exact and approximate sums (N+1 bits)
//   pair_count_o        : pairs accumulated
//   err_count_o         : pairs with a non-zero error distance
//   max_ed_o, sum_ed_o  : maximum and sum of |exact - approx|
module err_stats_acc
  import adder_eval_pkg::*;
#(
  parameter int N = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             upd_i,
  input  logic [EW(N)-1:0] exact_i,
  input  logic [EW(N)-1:0] approx_i,
  output logic [CW(N)-1:0] pair_count_o,
  output logic [CW(N)-1:0] err_count_o,
  output logic [EW(N)-1:0] max_ed_o,
  output logic [SW(N)-1:0] sum_ed_o
);
  localparam int EWL = EW(N);
  localparam int CWL = CW(N);
  localparam int SWL = SW(N);

  function automatic logic [EWL-1:0] abs_diff(input logic [EWL-1:0] x,
                                              input logic [EWL-1:0] y);
    return (x >= y) ? (x - y) : (y - x);
  endfunction

  logic [EWL-1:0] ed;
  logic [CWL-1:0] pair_q, pair_d;
  logic [CWL-1:0] err_q, err_d;
  logic [EWL-1:0] max_q, max_d;
  logic [SWL-1:0] sum_q, sum_d;

  always_comb begin
    ed     = abs_diff(exact_i, approx_i);
    pair_d = pair_q;
    err_d  = err_q;
    max_d  = max_q;
    sum_d  = sum_q;
    if (clr_i) begin
      pair_d = '0;
      err_d  = '0;
      max_d  = '0;
      sum_d  = '0;
    end else if (upd_i) begin
      pair_d = pair_q + CWL'(1);
      if (ed != '0) err_d = err_q + CWL'(1);
      if (ed > max_q) max_d = ed;
      sum_d = sum_q + SWL'(ed);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pair_q <= '0;
      err_q  <= '0;
      max_q  <= '0;
      sum_q  <= '0;
    end else begin
      pair_q <= pair_d;
      err_q  <= err_d;
      max_q  <= max_d;
      sum_q  <= sum_d;
    end
  end

  assign pair_count_o = pair_q;
  assign err_count_o  = err_q;
  assign max_ed_o     = max_q;
  assign sum_ed_o     = sum_q;

endmodule

// File: rtl/adder_sweep_ctrl.sv
// Synthesizable sweep controller for one approximate adder under test.
// Walks (i, j) over 0..A_MAX x 0..B_MAX in row-major order, skips pairs with
// i+j >= SUM_LIMIT, drives each accepted pair to the external adder, streams
// one record per pair and accumulates error statistics.
//   clk, rst           : clock, synchronous active-high reset
//   start, abort       : begin a sweep from IDLE / return to IDLE without done
//   op_a, op_b         : registered operands to the adder under test
//   dut_sum, dut_cout  : adder result
//   rec                : record stream (valid/ready, operands, exact, approx)
//   busy, done         : sweep in progress / one-cycle completion pulse
//   pair_count, err_count, max_ed, sum_ed : error statistics
module adder_sweep_ctrl
  import adder_eval_pkg::*;
#(
  parameter int N         = 8,
  parameter int A_MAX     = 127,
  parameter int B_MAX     = 127,
  parameter int SUM_LIMIT = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      abort,
  output logic [N-1:0]              op_a,
  output logic [N-1:0]              op_b,
  input  logic [N-1:0]              dut_sum,
  input  logic                      dut_cout,
  adder_sweep_ctrl_if.master        rec,
  output logic                      busy,
  output logic                      done,
  output logic [CW(N)-1:0]          pair_count,
  output logic [CW(N)-1:0]          err_count,
  output logic [EW(N)-1:0]          max_ed,
  output logic [SW(N)-1:0]          sum_ed
);
  localparam int EWL = EW(N);
  localparam logic [N-1:0]   A_LAST  = N'(A_MAX);
  localparam logic [N-1:0]   B_LAST  = N'(B_MAX);
  localparam logic [EWL-1:0] LIMIT_C = EWL'(SUM_LIMIT);

  state_e         state_q, state_d;
  logic [N-1:0]   i_q, i_d, j_q, j_d;
  logic [N-1:0]   op_a_q, op_a_d, op_b_q, op_b_d;
  logic           rec_valid_q, rec_valid_d;
  logic [N-1:0]   rec_a_q, rec_a_d, rec_b_q, rec_b_d;
  logic [EWL-1:0] rec_exact_q, rec_exact_d, rec_approx_q, rec_approx_d;

  logic [EWL-1:0] pair_sum, exact_w, approx_w;
  logic           accept, last_pair, hs;
  logic           stats_clr, stats_upd;
  state_e         step_state;
  logic [N-1:0]   step_i, step_j;

  // pair_sum is formed at N+1 bits so i+j never wraps before the compare
  assign pair_sum  = {1'b0, i_q} + {1'b0, j_q};
  assign accept    = pair_sum < LIMIT_C;
  assign last_pair = (i_q == A_LAST) && (j_q == B_LAST);
  assign exact_w   = {1'b0, op_a_q} + {1'b0, op_b_q};
  assign approx_w  = {dut_cout, dut_sum};
  assign hs        = rec_valid_q && rec.rec_ready;
  assign stats_clr = (state_q == ST_IDLE) && start && !abort;
  assign stats_upd = (state_q == ST_SAMPLE) && !abort;

  // Row-major advance shared by the skip path (CHECK) and the handshake path (OUT)
  always_comb begin
    step_state = ST_CHECK;
    step_i     = i_q;
    step_j     = j_q;
    if (last_pair) begin
      step_state = ST_DONE;
    end else if (j_q == B_LAST) begin
      step_i = i_q + N'(1);
      step_j = '0;
    end else begin
      step_j = j_q + N'(1);
    end
  end

  always_comb begin
    state_d      = state_q;
    i_d          = i_q;
    j_d          = j_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    rec_valid_d  = rec_valid_q;
    rec_a_d      = rec_a_q;
    rec_b_d      = rec_b_q;
    rec_exact_d  = rec_exact_q;
    rec_approx_d = rec_approx_q;
    if (abort) begin
      state_d     = ST_IDLE;
      rec_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_CHECK;
            i_d     = '0;
            j_d     = '0;
          end
        end
        ST_CHECK: begin
          if (accept) begin
            state_d = ST_APPLY;
          end else begin
            state_d = step_state;
            i_d     = step_i;
            j_d     = step_j;
          end
        end
        ST_APPLY: begin
          op_a_d  = i_q;
          op_b_d  = j_q;
          state_d = ST_SAMPLE;
        end
        // The adder has had a full cycle to settle on the registered operands
        ST_SAMPLE: begin
          rec_a_d      = op_a_q;
          rec_b_d      = op_b_q;
          rec_exact_d  = exact_w;
          rec_approx_d = approx_w;
          rec_valid_d  = 1'b1;
          state_d      = ST_OUT;
        end
        ST_OUT: begin
          if (hs) begin
            rec_valid_d = 1'b0;
            state_d     = step_state;
            i_d         = step_i;
            j_d         = step_j;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      i_q          <= '0;
      j_q          <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      rec_valid_q  <= 1'b0;
      rec_a_q      <= '0;
      rec_b_q      <= '0;
      rec_exact_q  <= '0;
      rec_approx_q <= '0;
    end else begin
      state_q      <= state_d;
      i_q          <= i_d;
      j_q          <= j_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      rec_valid_q  <= rec_valid_d;
      rec_a_q      <= rec_a_d;
      rec_b_q      <= rec_b_d;
      rec_exact_q  <= rec_exact_d;
      rec_approx_q <= rec_approx_d;
    end
  end

  err_stats_acc #(.N(N)) u_stats (
    .clk          (clk),
    .rst          (rst),
    .clr_i        (stats_clr),
    .upd_i        (stats_upd),
    .exact_i      (exact_w),
    .approx_i     (approx_w),
    .pair_count_o (pair_count),
    .err_count_o  (err_count),
    .max_ed_o     (max_ed),
    .sum_ed_o     (sum_ed)
  );

  assign op_a           = op_a_q;
  assign op_b           = op_b_q;
  assign rec.rec_valid  = rec_valid_q;
  assign rec.rec_a      = rec_a_q;
  assign rec.rec_b      = rec_b_q;
  assign rec.rec_exact  = rec_exact_q;
  assign rec.rec_approx = rec_approx_q;
  assign busy           = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done           = (state_q == ST_DONE);

endmodule

// File: tb/tb_adder_sweep_ctrl.sv
// Bench for adder_sweep_ctrl: three instances (ideal adder, bit0-stuck adder,
// ideal adder with a tight sum filter) on a shared clock, one selected at a time.
module tb_adder_sweep_ctrl;
  import adder_eval_pkg::*;

  localparam int N   = 4;
  localparam int EWL = EW(N);
  localparam int CWL = CW(N);
  localparam int SWL = SW(N);

  typedef struct packed {
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic [EWL-1:0] exact;
    logic [EWL-1:0] approx;
  } rec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic [2:0]     start_v;
  logic [2:0]     abort_v;
  logic           rec_ready;
  int             sel;
  int             checks   = 0;
  int             failures = 0;
  rec_t           exp_q[$];

  logic [N-1:0]   opa  [3];
  logic [N-1:0]   opb  [3];
  logic [N-1:0]   dsum [3];
  logic           dcout[3];
  logic           busy_v[3];
  logic           done_v[3];
  logic [CWL-1:0] pc_v[3];
  logic [CWL-1:0] ec_v[3];
  logic [EWL-1:0] mx_v[3];
  logic [SWL-1:0] se_v[3];
  logic [EWL-1:0] full0, full1, full2;

  adder_sweep_ctrl_if #(.N(N)) rif0 ();
  adder_sweep_ctrl_if #(.N(N)) rif1 ();
  adder_sweep_ctrl_if #(.N(N)) rif2 ();
  assign rif0.rec_ready = rec_ready;
  assign rif1.rec_ready = rec_ready;
  assign rif2.rec_ready = rec_ready;

  // Stub adders: ideal, sum bit0 stuck at 0, ideal
  assign full0 = {1'b0, opa[0]} + {1'b0, opb[0]};
  assign full1 = {1'b0, opa[1]} + {1'b0, opb[1]};
  assign full2 = {1'b0, opa[2]} + {1'b0, opb[2]};
  assign dsum[0] = full0[N-1:0];  assign dcout[0] = full0[N];
  assign dsum[1] = {full1[N-1:1], 1'b0};  assign dcout[1] = full1[N];
  assign dsum[2] = full2[N-1:0];  assign dcout[2] = full2[N];

  adder_sweep_ctrl #(.N(N), .A_MAX(3), .B_MAX(3), .SUM_LIMIT(16)) dut0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .abort(abort_v[0]),
    .op_a(opa[0]), .op_b(opb[0]), .dut_sum(dsum[0]), .dut_cout(dcout[0]),
    .rec(rif0), .busy(busy_v[0]), .done(done_v[0]),
    .pair_count(pc_v[0]), .err_count(ec_v[0]), .max_ed(mx_v[0]), .sum_ed(se_v[0]));

  adder_sweep_ctrl #(.N(N), .A_MAX(3), .B_MAX(3), .SUM_LIMIT(16)) dut1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .abort(abort_v[1]),
    .op_a(opa[1]), .op_b(opb[1]), .dut_sum(dsum[1]), .dut_cout(dcout[1]),
    .rec(rif1), .busy(busy_v[1]), .done(done_v[1]),
    .pair_count(pc_v[1]), .err_count(ec_v[1]), .max_ed(mx_v[1]), .sum_ed(se_v[1]));

  adder_sweep_ctrl #(.N(N), .A_MAX(3), .B_MAX(3), .SUM_LIMIT(4)) dut2 (
    .clk(clk), .rst(rst), .start(start_v[2]), .abort(abort_v[2]),
    .op_a(opa[2]), .op_b(opb[2]), .dut_sum(dsum[2]), .dut_cout(dcout[2]),
    .rec(rif2), .busy(busy_v[2]), .done(done_v[2]),
    .pair_count(pc_v[2]), .err_count(ec_v[2]), .max_ed(mx_v[2]), .sum_ed(se_v[2]));

  // Selected-instance view
  logic           m_valid, m_busy, m_done;
  logic [N-1:0]   m_a, m_b, m_opa, m_opb;
  logic [EWL-1:0] m_exact, m_approx, m_max;
  logic [CWL-1:0] m_pc, m_ec;
  logic [SWL-1:0] m_se;

  always_comb begin
    m_valid = rif0.rec_valid; m_a = rif0.rec_a; m_b = rif0.rec_b;
    m_exact = rif0.rec_exact; m_approx = rif0.rec_approx;
    if (sel == 1) begin
      m_valid = rif1.rec_valid; m_a = rif1.rec_a; m_b = rif1.rec_b;
      m_exact = rif1.rec_exact; m_approx = rif1.rec_approx;
    end else if (sel == 2) begin
      m_valid = rif2.rec_valid; m_a = rif2.rec_a; m_b = rif2.rec_b;
      m_exact = rif2.rec_exact; m_approx = rif2.rec_approx;
    end
    m_opa  = opa[sel];    m_opb  = opb[sel];
    m_busy = busy_v[sel]; m_done = done_v[sel];
    m_pc   = pc_v[sel];   m_ec   = ec_v[sel];
    m_max  = mx_v[sel];   m_se   = se_v[sel];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic set_sel(input int s);
    sel = s;
    #1;
  endtask

  task automatic check_zero(input string ctx);
    check({ctx, "_busy"},   64'(m_busy),   64'd0);
    check({ctx, "_done"},   64'(m_done),   64'd0);
    check({ctx, "_valid"},  64'(m_valid),  64'd0);
    check({ctx, "_op_a"},   64'(m_opa),    64'd0);
    check({ctx, "_op_b"},   64'(m_opb),    64'd0);
    check({ctx, "_rec_a"},  64'(m_a),      64'd0);
    check({ctx, "_rec_b"},  64'(m_b),      64'd0);
    check({ctx, "_exact"},  64'(m_exact),  64'd0);
    check({ctx, "_approx"}, 64'(m_approx), 64'd0);
    check({ctx, "_pc"},     64'(m_pc),     64'd0);
    check({ctx, "_ec"},     64'(m_ec),     64'd0);
    check({ctx, "_max"},    64'(m_max),    64'd0);
    check({ctx, "_sum"},    64'(m_se),     64'd0);
  endtask

  task automatic check_stats(input string ctx, input int pc, input int ec, input int mx, input int se);
    check({ctx, "_pair_count"}, 64'(m_pc), 64'(pc));
    check({ctx, "_err_count"},  64'(m_ec), 64'(ec));
    check({ctx, "_max_ed"},     64'(m_max), 64'(mx));
    check({ctx, "_sum_ed"},     64'(m_se), 64'(se));
  endtask

  task automatic push_expected(input int sl, input bit fault);
    rec_t r;
    for (int i = 0; i <= 3; i++) begin
      for (int j = 0; j <= 3; j++) begin
        if (i + j < sl) begin
          r.a      = N'(i);
          r.b      = N'(j);
          r.exact  = EWL'(i + j);
          r.approx = fault ? EWL'((i + j) & ~1) : EWL'(i + j);
          exp_q.push_back(r);
        end
      end
    end
  endtask

  task automatic do_start();
    start_v[sel] = 1'b1;
    @(posedge clk); #1;
    start_v = '0;
  endtask

  // Runs the selected sweep from the first cycle after start; c counts cycles
  // since leaving IDLE. Records are popped from the scoreboard on handshake.
  task automatic run_sweep(input string ctx, input int exp_done, input bit bp,
                           input bit glitch, input bit do_abort);
    int   c;
    int   bp_left;
    bit   fin;
    rec_t e;
    rec_t snap;
    logic [N-1:0] sa, sb;
    c = 0; fin = 1'b0; bp_left = bp ? 5 : 0;
    while (!fin) begin
      start_v[sel] = glitch && (c == 10);
      if (c > 300) begin
        check({ctx, "_cycle_budget"}, 64'(c), 64'(exp_done));
        fin = 1'b1;
      end else if (m_done) begin
        check({ctx, "_done_cycle"}, 64'(c), 64'(exp_done));
        check({ctx, "_left_in_queue"}, 64'(exp_q.size()), 64'd0);
        @(posedge clk); #1;
        check({ctx, "_done_one_cycle"}, 64'(m_done), 64'd0);
        check({ctx, "_idle_busy"}, 64'(m_busy), 64'd0);
        fin = 1'b1;
      end else begin
        if (m_valid && bp_left > 0 && m_a == 2 && m_b == 1) begin
          snap = '{a: m_a, b: m_b, exact: m_exact, approx: m_approx};
          sa = m_opa; sb = m_opb;
          rec_ready = 1'b0;
          repeat (5) begin
            @(posedge clk); #1; c++;
            check({ctx, "_bp_valid"}, 64'(m_valid), 64'd1);
            check({ctx, "_bp_rec"}, 64'({m_a, m_b, m_exact, m_approx}), 64'(snap));
            check({ctx, "_bp_ops"}, 64'({m_opa, m_opb}), 64'({sa, sb}));
          end
          rec_ready = 1'b1;
          bp_left = 0;
        end
        if (m_valid) begin
          if (exp_q.size() == 0) begin
            check({ctx, "_extra_record"}, 64'(m_valid), 64'd0);
          end else begin
            e = exp_q.pop_front();
            check({ctx, "_rec_a"},      64'(m_a),      64'(e.a));
            check({ctx, "_rec_b"},      64'(m_b),      64'(e.b));
            check({ctx, "_rec_exact"},  64'(m_exact),  64'(e.exact));
            check({ctx, "_rec_approx"}, 64'(m_approx), 64'(e.approx));
            check({ctx, "_op_a"},       64'(m_opa),    64'(e.a));
            check({ctx, "_op_b"},       64'(m_opb),    64'(e.b));
          end
          if (do_abort && m_a == 1 && m_b == 1) begin
            rec_ready = 1'b0;
            abort_v[sel] = 1'b1;
            @(posedge clk); #1;
            abort_v = '0;
            rec_ready = 1'b1;
            check({ctx, "_abort_busy"},  64'(m_busy),  64'd0);
            check({ctx, "_abort_valid"}, 64'(m_valid), 64'd0);
            check({ctx, "_abort_done"},  64'(m_done),  64'd0);
            check({ctx, "_abort_pc"},    64'(m_pc),    64'd6);
            check({ctx, "_abort_left"},  64'(exp_q.size()), 64'd10);
            repeat (3) begin
              @(posedge clk); #1;
              check({ctx, "_abort_no_done"}, 64'(m_done), 64'd0);
            end
            fin = 1'b1;
          end
        end
        if (!fin) begin
          @(posedge clk); #1; c++;
        end
      end
    end
    start_v = '0;
  endtask

  initial begin
    rst = 1'b1; start_v = '0; abort_v = '0; rec_ready = 1'b1; sel = 0;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      set_sel(s);
      check_zero("reset");
    end
    rst = 1'b0;
    set_sel(0);

    // Ideal adder, full range
    exp_q.delete(); push_expected(16, 1'b0);
    do_start();
    check("ideal_busy_after_start", 64'(m_busy), 64'd1);
    run_sweep("ideal", 64, 1'b0, 1'b0, 1'b0);
    check_stats("ideal", 16, 0, 0, 0);

    // Adder with sum bit0 stuck at zero
    set_sel(1);
    exp_q.delete(); push_expected(16, 1'b1);
    do_start();
    run_sweep("bit0", 64, 1'b0, 1'b0, 1'b0);
    check_stats("bit0", 16, 8, 1, 8);

    // Tight sum filter
    set_sel(2);
    exp_q.delete(); push_expected(4, 1'b0);
    do_start();
    run_sweep("filter", 46, 1'b0, 1'b0, 1'b0);
    check_stats("filter", 10, 0, 0, 0);

    // Backpressure on record (2,1)
    set_sel(0);
    exp_q.delete(); push_expected(16, 1'b0);
    do_start();
    run_sweep("bp", 69, 1'b1, 1'b0, 1'b0);
    check_stats("bp", 16, 0, 0, 0);

    // Stray start mid-sweep, then abort in OUT at (1,1)
    exp_q.delete(); push_expected(16, 1'b0);
    do_start();
    run_sweep("abort", 0, 1'b0, 1'b1, 1'b1);

    // Reset mid-sweep, then a fresh full sweep
    exp_q.delete();
    do_start();
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_zero("midrst");
    rst = 1'b0;
    exp_q.delete(); push_expected(16, 1'b0);
    do_start();
    run_sweep("rerun", 64, 1'b0, 1'b0, 1'b0);
    check_stats("rerun", 16, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
